// File: rtl/riscv_unrn_mtimer_if.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_unrn_mtimer_if
//  Purpose  : Single-cycle bus between the data-memory decoder and the mtimer.
//  Revision : 1.0  initial release
// ============================================================================
interface riscv_unrn_mtimer_if;
    logic        bus_req_i;
    logic        bus_we_i;
    logic [31:0] bus_addr_i;
    logic [31:0] bus_wdata_i;
    logic [31:0] bus_rdata_o;
    logic        bus_ack_o;
    logic        bus_err_o;

    modport master (
        output bus_req_i, bus_we_i, bus_addr_i, bus_wdata_i,
        input  bus_rdata_o, bus_ack_o, bus_err_o
    );

    modport slave (
        input  bus_req_i, bus_we_i, bus_addr_i, bus_wdata_i,
        output bus_rdata_o, bus_ack_o, bus_err_o
    );
endinterface
`default_nettype wire

// File: rtl/riscv_unrn_mtimer.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_unrn_mtimer
//  Purpose  : Memory-mapped 64-bit mtime/mtimecmp with registered MTIP output.
//             Optional tick prescaler enabled by `define MTIMER_PRESCALER_EN.
//  Revision : 1.0  initial release
// ============================================================================
module riscv_unrn_mtimer #(
    parameter int XLEN         = 32,
    parameter int PRESCALE_DIV = 10
) (
    input  wire                clk,
    input  wire                rst_n,
    riscv_unrn_mtimer_if.slave bus,
    output logic               mtip_o,
    output logic [63:0]        mtime_o
);

    typedef enum logic [1:0] {
        MTIME_LOW     = 2'd0,
        MTIME_HIGH    = 2'd1,
        MTIMECMP_LOW  = 2'd2,
        MTIMECMP_HIGH = 2'd3
    } mtime_address_t;

    localparam logic [31:0] C_BASE_ADDR = 32'h0000_8004;

    if (XLEN != 32 || PRESCALE_DIV < 1) begin : g_cfg_check
        $error("riscv_unrn_mtimer: XLEN must be 32 and PRESCALE_DIV >= 1");
    end

    logic [63:0]    mtime_q, mtime_d;
    logic [63:0]    mtimecmp_q, mtimecmp_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           ack_q, ack_d;
    logic           err_q, err_d;
    logic           mtip_q, mtip_d;

    logic [31:0]    w_off;
    logic           w_addr_ok;
    mtime_address_t w_sel;
    logic           w_rd;
    logic           w_wr;
    logic           w_mtime_wr;
    logic           w_tick;
    logic [31:0]    w_rd_val;

    // Offset from the first word; aligned and within four words means valid.
    assign w_off      = bus.bus_addr_i - C_BASE_ADDR;
    assign w_addr_ok  = (w_off[1:0] == 2'b00) && (w_off[31:4] == 28'd0);
    assign w_sel      = mtime_address_t'(w_off[3:2]);
    assign w_rd       = bus.bus_req_i && w_addr_ok && !bus.bus_we_i;
    assign w_wr       = bus.bus_req_i && w_addr_ok &&  bus.bus_we_i;
    assign w_mtime_wr = w_wr && ((w_sel == MTIME_LOW) || (w_sel == MTIME_HIGH));

`ifdef MTIMER_PRESCALER_EN
    localparam int               C_PS_W    = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [C_PS_W-1:0] C_PS_LAST = C_PS_W'(PRESCALE_DIV - 1);

    logic [C_PS_W-1:0] ps_cnt_q, ps_cnt_d;

    assign w_tick = (ps_cnt_q == C_PS_LAST);

    // A write to mtime restarts the prescale period.
    always_comb begin
        ps_cnt_d = ps_cnt_q + C_PS_W'(1);
        if (w_tick || w_mtime_wr) begin
            ps_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt_q <= '0;
        end else begin
            ps_cnt_q <= ps_cnt_d;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    always_comb begin
        w_rd_val = '0;
        case (w_sel)
            MTIME_LOW:     w_rd_val = mtime_q[31:0];
            MTIME_HIGH:    w_rd_val = mtime_q[63:32];
            MTIMECMP_LOW:  w_rd_val = mtimecmp_q[31:0];
            MTIMECMP_HIGH: w_rd_val = mtimecmp_q[63:32];
            default:       w_rd_val = '0;
        endcase
    end

    // A software write to either mtime half suppresses that cycle's tick.
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        if (w_wr && (w_sel == MTIME_LOW)) begin
            mtime_d = {mtime_q[63:32], bus.bus_wdata_i};
        end else if (w_wr && (w_sel == MTIME_HIGH)) begin
            mtime_d = {bus.bus_wdata_i, mtime_q[31:0]};
        end else if (w_tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (w_wr && (w_sel == MTIMECMP_LOW)) begin
            mtimecmp_d = {mtimecmp_q[63:32], bus.bus_wdata_i};
        end else if (w_wr && (w_sel == MTIMECMP_HIGH)) begin
            mtimecmp_d = {bus.bus_wdata_i, mtimecmp_q[31:0]};
        end
    end

    always_comb begin
        ack_d   = bus.bus_req_i;
        err_d   = bus.bus_req_i && !w_addr_ok;
        rdata_d = w_rd ? w_rd_val : 32'd0;
        mtip_d  = (mtime_d >= mtimecmp_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            mtip_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            mtip_q     <= mtip_d;
        end
    end

    assign bus.bus_rdata_o = rdata_q;
    assign bus.bus_ack_o   = ack_q;
    assign bus.bus_err_o   = err_q;
    assign mtip_o          = mtip_q;
    assign mtime_o         = mtime_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_unrn_mtimer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_unrn_mtimer
//  Purpose  : Self-checking bench for riscv_unrn_mtimer against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_riscv_unrn_mtimer;

    localparam int PS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mtip;
    logic [63:0] mtime;

    riscv_unrn_mtimer_if bus_if ();

    riscv_unrn_mtimer #(
        .XLEN         (32),
        .PRESCALE_DIV (PS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus_if),
        .mtip_o  (mtip),
        .mtime_o (mtime)
    );

    always #5 clk = ~clk;

    int cnt_vec = 0;
    int cnt_bad = 0;

    // Behavioural model: architectural timer state plus expected bus response.
    logic [63:0] m_time, m_cmp;
    int          m_ps;
    logic        exp_ack, exp_err, exp_mtip;
    logic [31:0] exp_rdata;

    task automatic model_reset();
        m_time    = 64'd0;
        m_cmp     = '1;
        m_ps      = 0;
        exp_ack   = 1'b0;
        exp_err   = 1'b0;
        exp_rdata = 32'd0;
        exp_mtip  = 1'b0;
    endtask

    task automatic step(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
        logic hit, wr_time, tick;
        int   idx;
        @(negedge clk);
        bus_if.bus_req_i   = req;
        bus_if.bus_we_i    = we;
        bus_if.bus_addr_i  = addr;
        bus_if.bus_wdata_i = wdata;
        hit = req && (addr == 32'h8004 || addr == 32'h8008 ||
                      addr == 32'h800C || addr == 32'h8010);
        idx = int'((addr - 32'h8004) >> 2);
        exp_ack   = req;
        exp_err   = req && !hit;
        exp_rdata = 32'd0;
        wr_time   = 1'b0;
        if (hit && !we) begin
            case (idx)
                0: exp_rdata = m_time[31:0];
                1: exp_rdata = m_time[63:32];
                2: exp_rdata = m_cmp[31:0];
                default: exp_rdata = m_cmp[63:32];
            endcase
        end
        if (hit && we) begin
            case (idx)
                0: begin m_time[31:0]  = wdata; wr_time = 1'b1; end
                1: begin m_time[63:32] = wdata; wr_time = 1'b1; end
                2: m_cmp[31:0]  = wdata;
                default: m_cmp[63:32] = wdata;
            endcase
        end
`ifdef MTIMER_PRESCALER_EN
        tick = (m_ps == PS - 1);
        m_ps = (tick || wr_time) ? 0 : m_ps + 1;
`else
        tick = 1'b1;
`endif
        if (tick && !wr_time) m_time = m_time + 64'd1;
        exp_mtip = (m_time >= m_cmp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus_if.bus_req_i   = 1'b0;
        bus_if.bus_we_i    = 1'b0;
        bus_if.bus_addr_i  = 32'd0;
        bus_if.bus_wdata_i = 32'd0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        cnt_vec += 5;
        if (bus_if.bus_ack_o !== 1'b0) begin cnt_bad++; $display("FAIL rst_ack got %b want 0", bus_if.bus_ack_o); end
        if (bus_if.bus_err_o !== 1'b0) begin cnt_bad++; $display("FAIL rst_err got %b want 0", bus_if.bus_err_o); end
        if (bus_if.bus_rdata_o !== 32'd0) begin cnt_bad++; $display("FAIL rst_rdata got %h want 0", bus_if.bus_rdata_o); end
        if (mtip !== 1'b0) begin cnt_bad++; $display("FAIL rst_mtip got %b want 0", mtip); end
        if (mtime !== 64'd0) begin cnt_bad++; $display("FAIL rst_mtime got %h want 0", mtime); end
    endtask

    task automatic test_count_read();
        repeat (5) step(1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 32'h8004, 32'd0);
        cnt_vec += 4;
        if (bus_if.bus_ack_o !== 1'b1) begin cnt_bad++; $display("FAIL cnt_ack got %b want 1", bus_if.bus_ack_o); end
        if (bus_if.bus_err_o !== 1'b0) begin cnt_bad++; $display("FAIL cnt_err got %b want 0", bus_if.bus_err_o); end
        if (bus_if.bus_rdata_o !== exp_rdata) begin cnt_bad++; $display("FAIL cnt_rdata got %0d want %0d", bus_if.bus_rdata_o, exp_rdata); end
        if (mtip !== 1'b0) begin cnt_bad++; $display("FAIL cnt_mtip got %b want 0", mtip); end
`ifndef MTIMER_PRESCALER_EN
        cnt_vec++;
        if (bus_if.bus_rdata_o !== 32'd5) begin cnt_bad++; $display("FAIL cnt_five got %0d want 5", bus_if.bus_rdata_o); end
`endif
        step(1'b0, 1'b0, 32'd0, 32'd0);
        cnt_vec++;
        if (bus_if.bus_ack_o !== 1'b0) begin cnt_bad++; $display("FAIL cnt_ack_drop got %b want 0", bus_if.bus_ack_o); end
    endtask

    task automatic test_carry();
        step(1'b1, 1'b1, 32'h8004, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 32'h8008, 32'h0000_0000);
        step(1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 32'h8008, 32'd0);
        cnt_vec += 2;
        if (bus_if.bus_rdata_o !== exp_rdata) begin cnt_bad++; $display("FAIL carry_hi got %h want %h", bus_if.bus_rdata_o, exp_rdata); end
        if (mtime !== m_time) begin cnt_bad++; $display("FAIL carry_mtime got %h want %h", mtime, m_time); end
        step(1'b1, 1'b1, 32'h8008, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 32'h8004, 32'hFFFF_FFFE);
        for (int i = 0; i < 3 * PS; i++) begin
            step(1'b0, 1'b0, 32'd0, 32'd0);
            cnt_vec += 2;
            if (mtime !== m_time) begin cnt_bad++; $display("FAIL wrap_mtime[%0d] got %h want %h", i, mtime, m_time); end
            if (mtip !== exp_mtip) begin cnt_bad++; $display("FAIL wrap_mtip[%0d] got %b want %b", i, mtip, exp_mtip); end
        end
    endtask

    task automatic test_mtip();
        step(1'b1, 1'b1, 32'h8008, 32'd0);
        step(1'b1, 1'b1, 32'h8004, 32'd0);
        step(1'b1, 1'b1, 32'h8010, 32'd0);
        step(1'b1, 1'b1, 32'h800C, 32'd100);
        step(1'b1, 1'b1, 32'h8004, 32'd95);
        for (int i = 0; i < 8 * PS; i++) begin
            step(1'b0, 1'b0, 32'd0, 32'd0);
            cnt_vec++;
            if (mtip !== exp_mtip) begin cnt_bad++; $display("FAIL mtip_rise[%0d] got %b want %b mtime=%0d", i, mtip, exp_mtip, m_time); end
        end
        step(1'b1, 1'b1, 32'h800C, 32'd1000);
        cnt_vec += 2;
        if (mtip !== 1'b0) begin cnt_bad++; $display("FAIL mtip_fall got %b want 0", mtip); end
        if (mtip !== exp_mtip) begin cnt_bad++; $display("FAIL mtip_fall_model got %b want %b", mtip, exp_mtip); end
    endtask

    task automatic test_errors();
        logic [31:0] bad [3];
        bad[0] = 32'h8006; bad[1] = 32'h8014; bad[2] = 32'h8000;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'(i == 2), bad[i], 32'hDEAD_BEEF);
            cnt_vec += 3;
            if (bus_if.bus_ack_o !== 1'b1) begin cnt_bad++; $display("FAIL err_ack[%0d] got %b want 1", i, bus_if.bus_ack_o); end
            if (bus_if.bus_err_o !== 1'b1) begin cnt_bad++; $display("FAIL err_flag[%0d] got %b want 1", i, bus_if.bus_err_o); end
            if (bus_if.bus_rdata_o !== 32'd0) begin cnt_bad++; $display("FAIL err_rdata[%0d] got %h want 0", i, bus_if.bus_rdata_o); end
        end
        step(1'b1, 1'b1, 32'h800A, 32'd7);
        for (int a = 0; a < 4; a++) begin
            step(1'b1, 1'b0, 32'h8004 + 32'(4 * a), 32'd0);
            cnt_vec += 2;
            if (bus_if.bus_err_o !== 1'b0) begin cnt_bad++; $display("FAIL err_clean[%0d] got %b want 0", a, bus_if.bus_err_o); end
            if (bus_if.bus_rdata_o !== exp_rdata) begin cnt_bad++; $display("FAIL err_state[%0d] got %h want %h", a, bus_if.bus_rdata_o, exp_rdata); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 32'h8004, 32'd0);
            cnt_vec += 2;
            if (bus_if.bus_ack_o !== 1'b1) begin cnt_bad++; $display("FAIL b2b_ack[%0d] got %b want 1", i, bus_if.bus_ack_o); end
            if (bus_if.bus_rdata_o !== exp_rdata) begin cnt_bad++; $display("FAIL b2b_rdata[%0d] got %h want %h", i, bus_if.bus_rdata_o, exp_rdata); end
        end
    endtask

    task automatic test_random();
        logic        req, we;
        logic [31:0] addr, wdata;
        for (int i = 0; i < 300; i++) begin
            req = 1'($urandom_range(0, 3) != 0);
            we  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0, 1: addr = 32'h8004;
                2:    addr = 32'h8008;
                3, 4: addr = 32'h800C;
                5:    addr = 32'h8010;
                6:    addr = 32'h8005 + 32'($urandom_range(0, 2));
                default: addr = 32'h8014;
            endcase
            wdata = (addr == 32'h8008 || addr == 32'h8010) ? 32'($urandom_range(0, 1))
                                                           : 32'($urandom_range(0, 400));
            step(req, we, addr, wdata);
            cnt_vec += 5;
            if (bus_if.bus_ack_o !== exp_ack) begin cnt_bad++; $display("FAIL rnd_ack[%0d] got %b want %b", i, bus_if.bus_ack_o, exp_ack); end
            if (bus_if.bus_err_o !== exp_err) begin cnt_bad++; $display("FAIL rnd_err[%0d] got %b want %b", i, bus_if.bus_err_o, exp_err); end
            if (bus_if.bus_rdata_o !== exp_rdata) begin cnt_bad++; $display("FAIL rnd_rdata[%0d] got %h want %h", i, bus_if.bus_rdata_o, exp_rdata); end
            if (mtip !== exp_mtip) begin cnt_bad++; $display("FAIL rnd_mtip[%0d] got %b want %b", i, mtip, exp_mtip); end
            if (mtime !== m_time) begin cnt_bad++; $display("FAIL rnd_mtime[%0d] got %h want %h", i, mtime, m_time); end
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b1, 32'h8010, 32'd0);
        step(1'b1, 1'b1, 32'h800C, 32'd0);
        step(1'b1, 1'b0, 32'h8004, 32'd0);
        cnt_vec += 2;
        if (mtip !== 1'b1) begin cnt_bad++; $display("FAIL ar_pre_mtip got %b want 1", mtip); end
        if (bus_if.bus_ack_o !== 1'b1) begin cnt_bad++; $display("FAIL ar_pre_ack got %b want 1", bus_if.bus_ack_o); end
        #2 rst_n = 1'b0;
        #1;
        cnt_vec += 4;
        if (mtip !== 1'b0) begin cnt_bad++; $display("FAIL ar_mtip got %b want 0", mtip); end
        if (bus_if.bus_ack_o !== 1'b0) begin cnt_bad++; $display("FAIL ar_ack got %b want 0", bus_if.bus_ack_o); end
        if (bus_if.bus_rdata_o !== 32'd0) begin cnt_bad++; $display("FAIL ar_rdata got %h want 0", bus_if.bus_rdata_o); end
        if (mtime !== 64'd0) begin cnt_bad++; $display("FAIL ar_mtime got %h want 0", mtime); end
        do_reset();
        step(1'b1, 1'b0, 32'h800C, 32'd0);
        cnt_vec++;
        if (bus_if.bus_rdata_o !== 32'hFFFF_FFFF) begin cnt_bad++; $display("FAIL ar_cmp_lo got %h want ffffffff", bus_if.bus_rdata_o); end
        step(1'b1, 1'b0, 32'h8010, 32'd0);
        cnt_vec++;
        if (bus_if.bus_rdata_o !== 32'hFFFF_FFFF) begin cnt_bad++; $display("FAIL ar_cmp_hi got %h want ffffffff", bus_if.bus_rdata_o); end
        // Write presented, then reset lands before the sampling edge.
        @(negedge clk);
        bus_if.bus_req_i   = 1'b1;
        bus_if.bus_we_i    = 1'b1;
        bus_if.bus_addr_i  = 32'h8004;
        bus_if.bus_wdata_i = 32'h0000_1234;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        cnt_vec++;
        if (bus_if.bus_ack_o !== 1'b0) begin cnt_bad++; $display("FAIL rma_ack got %b want 0", bus_if.bus_ack_o); end
        do_reset();
        step(1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 32'h8004, 32'd0);
        cnt_vec++;
        if (bus_if.bus_rdata_o !== exp_rdata) begin cnt_bad++; $display("FAIL rma_mtime got %h want %h", bus_if.bus_rdata_o, exp_rdata); end
    endtask

    initial begin
        test_reset();
        test_count_read();
        test_carry();
        test_mtip();
        test_errors();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", cnt_vec, cnt_bad);
        $finish;
    end

endmodule
`default_nettype wire
